// File: rtl/parallel2serial.sv
// parallel2serial: LSB-first serialiser with load/ready handshake and
// serial_start framing pulse, feeding the serial-to-parallel receiver.
// Optional one-entry holding buffer enabled by defining P2S_HOLD_BUF_EN.
module parallel2serial #(
   parameter int WIDTH      = 8,
   parameter int GAP_CYCLES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] data_in,
   output logic             ready,
   output logic             serial_start,
   output logic             d,
   output logic             busy,
   output logic             done,
   output logic [3:0]       counter
);

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      GAP
   } state_t;

   localparam logic [3:0] LAST_BIT = 4'(WIDTH - 1);
   localparam logic [3:0] LAST_GAP = 4'(GAP_CYCLES - 1);

   state_t           state, state_n;
   logic [WIDTH-1:0] shreg, shreg_n;
   logic [3:0]       bit_cnt, bit_cnt_n;
   logic [3:0]       gap_cnt, gap_cnt_n;
   logic             d_n, start_n, done_n;
   logic [3:0]       counter_n;
   logic             accept;
   logic             launch;
   logic [WIDTH-1:0] launch_word;

`ifdef P2S_HOLD_BUF_EN
   logic             buf_full, buf_full_n;
   logic [WIDTH-1:0] buf_data, buf_data_n;

   assign ready = !buf_full;
`else
   assign ready = (state == IDLE);
`endif

   assign accept = load && ready;
   assign busy   = (state != IDLE);

   // Next-state, shift-register and registered-output computation
   always_comb begin
      state_n     = state;
      shreg_n     = shreg;
      bit_cnt_n   = bit_cnt;
      gap_cnt_n   = gap_cnt;
      d_n         = 1'b0;
      start_n     = 1'b0;
      done_n      = 1'b0;
      counter_n   = '0;
      launch      = 1'b0;
      launch_word = data_in;
`ifdef P2S_HOLD_BUF_EN
      buf_full_n  = buf_full;
      buf_data_n  = buf_data;
      // Words accepted while a frame is in flight wait in the buffer
      if (accept && (state != IDLE)) begin
         buf_full_n = 1'b1;
         buf_data_n = data_in;
      end
`endif

      case (state)
         IDLE: begin
`ifdef P2S_HOLD_BUF_EN
            // Only reachable with a full buffer when GAP_CYCLES is 0: the
            // done cycle doubles as the single mandatory idle cycle on d.
            if (buf_full) begin
               launch      = 1'b1;
               launch_word = buf_data;
               buf_full_n  = 1'b0;
            end else
`endif
            if (accept) begin
               launch      = 1'b1;
               launch_word = data_in;
            end
         end

         SEND: begin
            if (bit_cnt == LAST_BIT) begin
               done_n    = 1'b1;
               shreg_n   = '0;
               bit_cnt_n = '0;
               gap_cnt_n = '0;
               if (GAP_CYCLES == 0) begin
                  state_n = IDLE;
               end else begin
                  state_n = GAP;
               end
            end else begin
               bit_cnt_n = bit_cnt + 4'd1;
               counter_n = bit_cnt + 4'd1;
               shreg_n   = shreg >> 1;
               d_n       = shreg[1];
            end
         end

         GAP: begin
            if (gap_cnt == LAST_GAP) begin
               state_n   = IDLE;
               gap_cnt_n = '0;
`ifdef P2S_HOLD_BUF_EN
               if (buf_full) begin
                  launch      = 1'b1;
                  launch_word = buf_data;
                  buf_full_n  = 1'b0;
               end
`endif
            end else begin
               gap_cnt_n = gap_cnt + 4'd1;
            end
         end

         default: state_n = IDLE;
      endcase

      // Starting a frame: bit 0 goes straight onto d with serial_start
      if (launch) begin
         state_n   = SEND;
         shreg_n   = launch_word;
         bit_cnt_n = '0;
         d_n       = launch_word[0];
         start_n   = 1'b1;
         counter_n = '0;
      end
   end

   // State and output registers with synchronous active-high reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         shreg        <= '0;
         bit_cnt      <= '0;
         gap_cnt      <= '0;
         d            <= 1'b0;
         serial_start <= 1'b0;
         done         <= 1'b0;
         counter      <= '0;
`ifdef P2S_HOLD_BUF_EN
         buf_full     <= 1'b0;
         buf_data     <= '0;
`endif
      end else begin
         state        <= state_n;
         shreg        <= shreg_n;
         bit_cnt      <= bit_cnt_n;
         gap_cnt      <= gap_cnt_n;
         d            <= d_n;
         serial_start <= start_n;
         done         <= done_n;
         counter      <= counter_n;
`ifdef P2S_HOLD_BUF_EN
         buf_full     <= buf_full_n;
         buf_data     <= buf_data_n;
`endif
      end
   end

endmodule
